gearbox_tx_ctrl: RTL and testbench

GEARBOX_TX_CTRL -- requirements
Module: gearbox_tx_ctrl

---
 rtl/gearbox_pkg.sv | 19 +
 rtl/gearbox_tx_ctrl.sv | 133 +++++++++++++
 tb/tb_gearbox_tx_ctrl.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gearbox_pkg.sv
// Shared definitions for the gearbox transmit path: default sync header
// width, the sync header codes and the sequencing FSM state type.
package gearbox_pkg;

  // Default sync header width in bits.
  localparam int HEAD_W_DEF = 2;

  // Sync header codes carried ahead of each block.
  localparam logic [1:0] SYNC_DATA = 2'b01;
  localparam logic [1:0] SYNC_CTRL = 2'b10;

  // Transmit sequencing FSM.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FULL = 2'd2
  } gb_state_t;

endpackage

// File: rtl/gearbox_tx_ctrl.sv
// Gearbox transmit controller. It sequences the beats of each block
// (beat_o), counts completed blocks (seq_o) and, once the gearbox has
// accumulated a full sequence of headers, spends one cycle draining its
// buffer (full_v_o) while the upstream is stalled. The outputs drive the
// gearbox_tx seq_i input and the upstream stall (ready_o).
//
// Per-sequence timeline from RUN entry:
//   seq 0 .. SEQ_FULL-1 : ready_o=1, one beat accepted per cycle
//   seq == SEQ_FULL     : ready_o=0, full_v_o=1 (drain cycle, still in RUN)
//   ST_FULL             : one settling cycle, seq and beat held at 0
// after which sequencing resumes at seq 0, beat 0.
module gearbox_tx_ctrl
  import gearbox_pkg::*;
#(
  parameter  int BLOCK_DATA_W = 64,
  parameter  int DATA_W       = 64,
  parameter  int HEAD_W       = HEAD_W_DEF,
  localparam int SEQ_FULL     = DATA_W / HEAD_W,
  localparam int SEQ_W        = $clog2(SEQ_FULL + 1),
  localparam int CNT_N        = BLOCK_DATA_W / DATA_W,
  localparam int CNT_W        = (CNT_N > 1) ? $clog2(CNT_N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [SEQ_W-1:0] seq_o,
  output logic [CNT_W-1:0] beat_o,
  output logic             head_v_o,
  output logic             full_v_o,
  output logic             underrun_o
);

  // Terminal counts, sized to the counter registers.
  localparam logic [SEQ_W-1:0] SEQ_MAX   = SEQ_W'(SEQ_FULL);
  localparam logic [CNT_W-1:0] BEAT_LAST = CNT_W'(CNT_N - 1);

  gb_state_t        state_q, state_d;
  logic [SEQ_W-1:0] seq_q, seq_d;
  logic [CNT_W-1:0] beat_q, beat_d;
  logic             underrun_q, underrun_d;

  logic             full_v;
  logic             ready;
  logic             last_beat;

  // Output decode: a single level of logic on registered state only, so
  // valid_i never reaches ready_o combinationally.
  always_comb begin
    full_v    = (seq_q == SEQ_MAX);
    ready     = (state_q == ST_RUN) && !full_v;
    // With one beat per block BEAT_LAST is 0, so every cycle closes a block
    // and beat stays at 0 while seq advances each cycle.
    last_beat = (beat_q == BEAT_LAST);
  end

  // Next-state, counter and sticky-flag update.
  always_comb begin
    state_d    = state_q;
    seq_d      = seq_q;
    beat_d     = beat_q;
    underrun_d = underrun_q | (ready & ~valid_i);

    unique case (state_q)
      ST_IDLE: begin
        seq_d  = '0;
        beat_d = '0;
        if (en_i) begin
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        if (full_v) begin
          // Drain cycle: no beat accepted, counters restart after FULL.
          state_d = ST_FULL;
          seq_d   = '0;
          beat_d  = '0;
        end else if (last_beat) begin
          // Block boundary: the only point where en_i=0 takes effect.
          beat_d = '0;
          if (!en_i) begin
            state_d = ST_IDLE;
            seq_d   = '0;
          end else begin
            seq_d = seq_q + SEQ_W'(1);
          end
        end else begin
          beat_d = beat_q + CNT_W'(1);
        end
      end

      ST_FULL: begin
        seq_d   = '0;
        beat_d  = '0;
        state_d = en_i ? ST_RUN : ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        seq_d   = '0;
        beat_d  = '0;
      end
    endcase
  end

  // State and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      seq_q      <= '0;
      beat_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      seq_q      <= seq_d;
      beat_q     <= beat_d;
      underrun_q <= underrun_d;
    end
  end

  // Output drive.
  always_comb begin
    ready_o    = ready;
    seq_o      = seq_q;
    beat_o     = beat_q;
    head_v_o   = ready & (beat_q == '0);
    full_v_o   = full_v;
    underrun_o = underrun_q;
  end

endmodule

// File: tb/tb_gearbox_tx_ctrl.sv
// Self-checking bench for gearbox_tx_ctrl. Two instances run side by side
// (64-bit beats: one beat per block; 16-bit beats: four beats per block).
// The reference model counts accepted beats per sequence and derives
// seq/beat arithmetically; expected outputs are queued by the stimulus and
// compared by an independent monitor.
module tb_gearbox_tx_ctrl;

  localparam int SF64 = 32;
  localparam int CN64 = 1;
  localparam int SF16 = 8;
  localparam int CN16 = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en_i = 1'b0;
  logic       valid_i = 1'b0;

  logic       rdy64, head64, full64, und64;
  logic [5:0] seq64;
  logic [0:0] beat64;
  logic       rdy16, head16, full16, und16;
  logic [3:0] seq16;
  logic [1:0] beat16;

  gearbox_tx_ctrl #(.BLOCK_DATA_W(64), .DATA_W(64), .HEAD_W(2)) u64 (
    .clk(clk), .reset(reset), .en_i(en_i), .valid_i(valid_i),
    .ready_o(rdy64), .seq_o(seq64), .beat_o(beat64), .head_v_o(head64),
    .full_v_o(full64), .underrun_o(und64)
  );

  gearbox_tx_ctrl #(.BLOCK_DATA_W(64), .DATA_W(16), .HEAD_W(2)) u16 (
    .clk(clk), .reset(reset), .en_i(en_i), .valid_i(valid_i),
    .ready_o(rdy16), .seq_o(seq16), .beat_o(beat16), .head_v_o(head16),
    .full_v_o(full16), .underrun_o(und16)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit running;
    bit draining;
    bit underrun;
    int acc;
  } model_t;

  typedef struct {
    int ready;
    int seq;
    int beat;
    int head;
    int full;
    int under;
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;
  model_t m64, m16;
  exp_t   q64[$];
  exp_t   q16[$];

  function automatic exp_t predict(model_t m, int cn, int sf);
    exp_t e;
    int   total;
    total   = cn * sf;
    e.ready = (m.running && m.acc < total) ? 1 : 0;
    e.full  = (m.running && m.acc == total) ? 1 : 0;
    e.seq   = m.acc / cn;
    e.beat  = m.acc % cn;
    e.head  = (e.ready == 1 && e.beat == 0) ? 1 : 0;
    e.under = m.underrun ? 1 : 0;
    return e;
  endfunction

  function automatic model_t advance(model_t m, bit en, bit valid, int cn, int sf);
    model_t n;
    int     total;
    n     = m;
    total = cn * sf;
    if (m.draining) begin
      n.draining = 1'b0;
      n.running  = en;
      n.acc      = 0;
    end else if (!m.running) begin
      n.running = en;
      n.acc     = 0;
    end else if (m.acc == total) begin
      n.running  = 1'b0;
      n.draining = 1'b1;
      n.acc      = 0;
    end else begin
      if (!valid) n.underrun = 1'b1;
      n.acc = m.acc + 1;
      if ((n.acc % cn) == 0 && !en) begin
        n.running = 1'b0;
        n.acc     = 0;
      end
    end
    return n;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_u64_ready"}, int'(rdy64), 0);
    chk({tag, "_u64_seq"}, int'(seq64), 0);
    chk({tag, "_u64_beat"}, int'(beat64), 0);
    chk({tag, "_u64_head"}, int'(head64), 0);
    chk({tag, "_u64_full"}, int'(full64), 0);
    chk({tag, "_u64_underrun"}, int'(und64), 0);
    chk({tag, "_u16_ready"}, int'(rdy16), 0);
    chk({tag, "_u16_seq"}, int'(seq16), 0);
    chk({tag, "_u16_beat"}, int'(beat16), 0);
    chk({tag, "_u16_head"}, int'(head16), 0);
    chk({tag, "_u16_full"}, int'(full16), 0);
    chk({tag, "_u16_underrun"}, int'(und16), 0);
  endtask

  // Assert reset, check outputs clear at once, release on a falling edge.
  task automatic do_reset();
    mon_en  = 1'b0;
    en_i    = 1'b0;
    valid_i = 1'b0;
    reset   = 1'b1;
    #1;
    chk_zero_outputs("reset");
    q64.delete();
    q16.delete();
    m64 = '{running: 1'b0, draining: 1'b0, underrun: 1'b0, acc: 0};
    m16 = '{running: 1'b0, draining: 1'b0, underrun: 1'b0, acc: 0};
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // One clock: drive inputs at the falling edge, predict the outputs that
  // follow the rising edge, then return at the next falling edge.
  task automatic cycle(input bit en, input bit valid);
    en_i    = en;
    valid_i = valid;
    mon_en  = 1'b1;
    @(posedge clk);
    m64 = advance(m64, en, valid, CN64, SF64);
    q64.push_back(predict(m64, CN64, SF64));
    m16 = advance(m16, en, valid, CN16, SF16);
    q16.push_back(predict(m16, CN16, SF16));
    @(negedge clk);
  endtask

  // Monitor: compares every presented cycle against the queued prediction
  // and checks the standing invariants.
  initial begin
    exp_t e;
    bit   prev64, prev16;
    prev64 = 1'b0;
    prev16 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        if (q64.size() == 0 || q16.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: actual q64=%0d q16=%0d required nonempty at %0t",
                   q64.size(), q16.size(), $time);
        end else begin
          e = q64.pop_front();
          chk("u64_ready", int'(rdy64), e.ready);
          chk("u64_seq", int'(seq64), e.seq);
          chk("u64_beat", int'(beat64), e.beat);
          chk("u64_head", int'(head64), e.head);
          chk("u64_full", int'(full64), e.full);
          chk("u64_underrun", int'(und64), e.under);
          e = q16.pop_front();
          chk("u16_ready", int'(rdy16), e.ready);
          chk("u16_seq", int'(seq16), e.seq);
          chk("u16_beat", int'(beat16), e.beat);
          chk("u16_head", int'(head16), e.head);
          chk("u16_full", int'(full16), e.full);
          chk("u16_underrun", int'(und16), e.under);
          chk("u64_seq_bound", (int'(seq64) <= SF64) ? 1 : 0, 1);
          chk("u16_seq_bound", (int'(seq16) <= SF16) ? 1 : 0, 1);
          chk("u64_full_and_ready", (full64 && rdy64) ? 1 : 0, 0);
          chk("u16_full_and_ready", (full16 && rdy16) ? 1 : 0, 0);
          chk("u64_full_twice", (full64 && prev64) ? 1 : 0, 0);
          chk("u16_full_twice", (full16 && prev16) ? 1 : 0, 0);
          prev64 = full64;
          prev16 = full16;
        end
      end else begin
        prev64 = 1'b0;
        prev16 = 1'b0;
      end
    end
  end

  // Stimulus.
  initial begin
    #2;
    do_reset();

    // Continuous run: drain cycles 33 and 67 cycles after en_i is applied.
    for (int k = 1; k <= 70; k++) begin
      cycle(1'b1, 1'b1);
      if (k == 33 || k == 67) begin
        chk("u64_full_wrap", int'(full64), 1);
        chk("u64_ready_wrap", int'(rdy64), 0);
        chk("u64_seq_wrap", int'(seq64), SF64);
        chk("u16_full_wrap", int'(full16), 1);
      end
      if (k == 34 || k == 68) begin
        chk("u64_seq_after_full", int'(seq64), 0);
        chk("u64_full_after_full", int'(full64), 0);
      end
    end

    // en_i dropped mid-block on the 16-bit instance.
    do_reset();
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    chk("u16_beat_before_drop", int'(beat16), 1);
    cycle(1'b0, 1'b1);
    chk("u16_ready_beat2", int'(rdy16), 1);
    chk("u16_beat2", int'(beat16), 2);
    cycle(1'b0, 1'b1);
    chk("u16_ready_beat3", int'(rdy16), 1);
    chk("u16_beat3", int'(beat16), 3);
    cycle(1'b0, 1'b1);
    chk("u16_idle_ready", int'(rdy16), 0);
    chk("u16_idle_seq", int'(seq16), 0);

    // Single missing beat sets the sticky underrun flag.
    do_reset();
    repeat (3) cycle(1'b1, 1'b1);
    chk("u16_underrun_clear", int'(und16), 0);
    cycle(1'b1, 1'b0);
    chk("u64_underrun_set", int'(und64), 1);
    chk("u16_underrun_set", int'(und16), 1);
    repeat (5) cycle(1'b1, 1'b1);
    chk("u64_underrun_sticky", int'(und64), 1);
    chk("u64_seq_counting", int'(seq64), 8);

    // Reset while draining, then restart from zero with a header beat.
    do_reset();
    repeat (33) cycle(1'b1, 1'b1);
    chk("u64_full_before_reset", int'(full64), 1);
    chk("u64_seq_before_reset", int'(seq64), SF64);
    do_reset();
    cycle(1'b1, 1'b1);
    chk("u64_restart_seq", int'(seq64), 0);
    chk("u64_restart_head", int'(head64), 1);
    chk("u16_restart_head", int'(head16), 1);

    // Randomised en_i/valid_i with occasional resets.
    do_reset();
    for (int k = 0; k < 10000; k++) begin
      if ($urandom_range(0, 1499) == 0) do_reset();
      cycle($urandom_range(0, 9) != 0, $urandom_range(0, 19) != 0);
    end

    mon_en = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion, %0d checks, %0d errors",
             checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
